image_draw: RTL
===============

IMAGE_DRAW -- requirements
Module: image_draw

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 20, meaning image ROM address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 12, meaning the ROM pixel width in 4:4:4 RGB format.
REQ-003 The module SHALL have parameters IMG_W (default 1024) and IMG_H (default 768), meaning image width and height in pixels.
REQ-004 The module SHALL have parameters XPOS (default 0) and YPOS (default 0), meaning the image top-left position on screen.
REQ-005 The module SHALL have parameter KEY_COLOR, default 12'hF0F, meaning the transparent pixel value.
REQ-006 The module SHALL have port clk, input, 1 bit: system clock; all logic is posedge.
REQ-007 The module SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-008 The module SHALL have port draw_en, input, 1 bit: request to draw the image.
REQ-009 The module SHALL have ports hcount_in and vcount_in, input, 11 bits each: VGA pixel counters.
REQ-010 The module SHALL have ports hsync_in, vsync_in, hblnk_in and vblnk_in, input, 1 bit each: VGA timing signals; blanks are active-high.
REQ-011 The module SHALL have port rgb_in, input, 12 bits: background pixel.
REQ-012 The module SHALL have port rom_addr, output, ADDR_WIDTH bits: read address to the image ROM.
REQ-013 The module SHALL have port rom_data, input, DATA_WIDTH bits: ROM pixel, registered by the ROM one clk after rom_addr.
REQ-014 The module SHALL have ports hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out and rgb_out, all outputs, with the same widths as their inputs: delayed VGA stream.

Function
REQ-015 The module SHALL have a two-state controller with states IDLE (pass-through) and ACTIVE (draw).
REQ-016 State transitions SHALL occur only on the frame-start pixel (hcount_in==0 && vcount_in==0): ACTIVE if draw_en=1, otherwise IDLE.
REQ-017 Any draw_en change mid-frame SHALL have no effect until the next frame start, so no partially drawn frames occur.
REQ-018 A pixel SHALL be in-window when XPOS<=hcount_in<XPOS+IMG_W, YPOS<=vcount_in<YPOS+IMG_H, and both blanks are 0.
REQ-019 Stage 1 SHALL register rom_addr = (vcount_in-YPOS)*IMG_W + (hcount_in-XPOS), truncated to ADDR_WIDTH, on in-window pixels, and SHALL hold its previous value on all other pixels.
REQ-020 Stage 1 SHALL also register the in-window flag qualified by the state (after any frame-start update), together with all timing signals and rgb_in.
REQ-021 Stage 2 SHALL delay the timing signals, the rgb value and the flag by one more clk, aligned with rom_data.
REQ-022 Stage 3 SHALL register the outputs as follows: rgb_out = rom_data if flag=1 and rom_data!=KEY_COLOR; otherwise the delayed rgb_in.
REQ-023 Latency from any input to its corresponding output SHALL be exactly 3 clk for all outputs, with the timing signals and rgb mutually aligned.
REQ-024 Pixels in blanking SHALL never take ROM data; rgb_out SHALL equal the delayed rgb_in there.
REQ-025 A window extending past the active area SHALL be clipped naturally by the blank qualification; no wrap-around onto other lines is permitted.
REQ-026 The last image pixel (IMG_W-1, IMG_H-1) SHALL address IMG_W*IMG_H-1; addresses SHALL never exceed this value.

Reset
REQ-027 While rst=1, the state SHALL be IDLE, rom_addr SHALL be 0, all pipeline registers SHALL be 0, and all outputs SHALL be 0.
REQ-028 Reset mid-frame SHALL return the block to IDLE; drawing SHALL resume only at the first frame start after release with draw_en=1.

Verification
REQ-029 Bench: rst pulse mid-line -> all outputs 0 immediately (async) and held during rst; IDLE after release.
REQ-030 Bench: draw_en=1 before frame start; ROM model returns addr[11:0] -> at pixel (5,2) rgb_out=rom content of address 2*1024+5=2053, appearing 3 clk after input.
REQ-031 Bench: draw_en=1 rising mid-frame (vcount 300) -> rgb_out equals rgb_in for the rest of the frame; image drawn from the next frame start.
REQ-032 Bench: ROM returns 12'hF0F at one pixel -> rgb_out equals the background value there; neighbours show ROM data.
REQ-033 Bench: XPOS=100, YPOS=50, IMG_W=64, IMG_H=32 -> (99,50) background, (100,50) address 0, (163,81) address 2047, (164,81) background.
REQ-034 Bench: all timing signals compared with inputs delayed 3 clk over a full frame -> zero mismatches.

Source files
------------

// File: rtl/image_draw.sv
// image_draw: overlays an image held in an external ROM onto a VGA pixel stream.
// A three-stage pipeline (address, ROM wait, colour select) keeps the timing
// signals and colour aligned with the one-clock ROM read latency. Pixels equal
// to KEY_COLOR are transparent and let the background through.
module image_draw #(
   parameter int                    ADDR_WIDTH = 20,
   parameter int                    DATA_WIDTH = 12,
   parameter int                    IMG_W      = 1024,
   parameter int                    IMG_H      = 768,
   parameter int                    XPOS       = 0,
   parameter int                    YPOS       = 0,
   parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  draw_en,
   input  logic [10:0]           hcount_in,
   input  logic [10:0]           vcount_in,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  hblnk_in,
   input  logic                  vblnk_in,
   input  logic [11:0]           rgb_in,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   output logic [10:0]           hcount_out,
   output logic [10:0]           vcount_out,
   output logic                  hsync_out,
   output logic                  vsync_out,
   output logic                  hblnk_out,
   output logic                  vblnk_out,
   output logic [11:0]           rgb_out
);

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Window geometry widened to 32 bits so offsets and products never overflow.
   localparam logic [31:0] X_OFS = 32'(XPOS);
   localparam logic [31:0] Y_OFS = 32'(YPOS);
   localparam logic [31:0] W_EXT = 32'(IMG_W);
   localparam logic [31:0] H_EXT = 32'(IMG_H);

   state_t                  state;
   state_t                  next_state;
   logic                    frame_start;
   logic                    in_window;
   logic [31:0]             h_ext;
   logic [31:0]             v_ext;
   logic [31:0]             rel_x;
   logic [31:0]             rel_y;
   logic [ADDR_WIDTH-1:0]   addr_calc;

   logic [10:0]             s1_hcount;
   logic [10:0]             s1_vcount;
   logic                    s1_hsync;
   logic                    s1_vsync;
   logic                    s1_hblnk;
   logic                    s1_vblnk;
   logic [11:0]             s1_rgb;
   logic                    s1_flag;

   logic [10:0]             s2_hcount;
   logic [10:0]             s2_vcount;
   logic                    s2_hsync;
   logic                    s2_vsync;
   logic                    s2_hblnk;
   logic                    s2_vblnk;
   logic [11:0]             s2_rgb;
   logic                    s2_flag;

   assign h_ext       = {21'd0, hcount_in};
   assign v_ext       = {21'd0, vcount_in};
   assign frame_start = (hcount_in == 11'd0) && (vcount_in == 11'd0);

   // The draw decision is only re-evaluated on the first pixel of a frame.
   always_comb begin
      next_state = state;
      if (frame_start) begin
         next_state = draw_en ? ACTIVE : IDLE;
      end
   end

   // Offsets below the window wrap to huge unsigned values, so a single
   // less-than test per axis covers both window edges.
   always_comb begin
      rel_x     = h_ext - X_OFS;
      rel_y     = v_ext - Y_OFS;
      in_window = (rel_x < W_EXT) && (rel_y < H_EXT) && !hblnk_in && !vblnk_in;
      addr_calc = ADDR_WIDTH'(rel_y * W_EXT + rel_x);
   end

   // Controller register: pass-through or draw, latched per frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Stage 1: issue the ROM address and capture the stream with the draw flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr  <= '0;
         s1_hcount <= '0;
         s1_vcount <= '0;
         s1_hsync  <= 1'b0;
         s1_vsync  <= 1'b0;
         s1_hblnk  <= 1'b0;
         s1_vblnk  <= 1'b0;
         s1_rgb    <= '0;
         s1_flag   <= 1'b0;
      end else begin
         if (in_window) begin
            rom_addr <= addr_calc;
         end
         s1_hcount <= hcount_in;
         s1_vcount <= vcount_in;
         s1_hsync  <= hsync_in;
         s1_vsync  <= vsync_in;
         s1_hblnk  <= hblnk_in;
         s1_vblnk  <= vblnk_in;
         s1_rgb    <= rgb_in;
         s1_flag   <= in_window && (next_state == ACTIVE);
      end
   end

   // Stage 2: wait one clock while the ROM registers the requested pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_hcount <= '0;
         s2_vcount <= '0;
         s2_hsync  <= 1'b0;
         s2_vsync  <= 1'b0;
         s2_hblnk  <= 1'b0;
         s2_vblnk  <= 1'b0;
         s2_rgb    <= '0;
         s2_flag   <= 1'b0;
      end else begin
         s2_hcount <= s1_hcount;
         s2_vcount <= s1_vcount;
         s2_hsync  <= s1_hsync;
         s2_vsync  <= s1_vsync;
         s2_hblnk  <= s1_hblnk;
         s2_vblnk  <= s1_vblnk;
         s2_rgb    <= s1_rgb;
         s2_flag   <= s1_flag;
      end
   end

   // Stage 3: pick image or background colour and register all outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= s2_hcount;
         vcount_out <= s2_vcount;
         hsync_out  <= s2_hsync;
         vsync_out  <= s2_vsync;
         hblnk_out  <= s2_hblnk;
         vblnk_out  <= s2_vblnk;
         if (s2_flag && (rom_data != KEY_COLOR)) begin
            rgb_out <= 12'(rom_data);
         end else begin
            rgb_out <= s2_rgb;
         end
      end
   end

endmodule
